rx: RTL and testbench

Serial receiver at the far end of the synchronous TX/RX link. It accepts an LSB-first bit stream qualified by `tx_valid` and paces the transmitter with `rx_ready`. It deserialises one message of 2^ADDR_WIDTH words into an internal register-file buffer and flags completion when the transmitter asserts `tx_finish`. A registered read port lets downstream logic or the bench retrieve the captured words.

---
 rtl/rx_pkg.sv | 15 +
 rtl/rx_if.sv | 31 +++
 rtl/rx_sm.sv | 113 +++++++++++
 rtl/rx.sv | 109 ++++++++++
 tb/tb_rx.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared types and default widths for the serial receiver.
package rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;

  typedef enum logic [2:0] {
    READY = 3'd0,
    RECV  = 3'd1,
    STORE = 3'd2,
    FULL  = 3'd3,
    DONE  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_if.sv
// Serial link, read port and status bundle between a transmitter/reader (master)
// and the receiver (slave).
interface rx_if
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  tx_data;
  logic                  tx_valid;
  logic                  tx_finish;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  rx_done;
  logic                  rx_error;
  logic [DATA_WIDTH-1:0] rx_checksum;

  modport master (
    output tx_data, tx_valid, tx_finish, rd_addr,
    input  rx_ready, rd_data, word_count, rx_done, rx_error, rx_checksum
  );

  modport slave (
    input  tx_data, tx_valid, tx_finish, rd_addr,
    output rx_ready, rd_data, word_count, rx_done, rx_error, rx_checksum
  );

endinterface

// File: rtl/rx_sm.sv
// Receiver control: protocol state machine, bit counter and registered
// ready/done/error status.
module rx_sm
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_valid,
  input  logic tx_finish,
  input  logic last_word,
  output logic shift_en,
  output logic store,
  output logic rx_ready,
  output logic rx_error,
  output logic rx_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  rx_state_e        state_r;
  rx_state_e        state_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_cnt_s;
  logic             err_set_s;

  // Next-state, bit counter and error-event decode.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shift_en  = 1'b0;
    store     = 1'b0;
    err_set_s = 1'b0;
    case (state_r)
      READY: begin
        if (tx_valid) begin
          shift_en  = 1'b1;
          bit_cnt_s = CNT_W'(1);
          state_s   = RECV;
        end else if (tx_finish) begin
          err_set_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s = READY;
        end
      end
      RECV: begin
        if (tx_valid) begin
          shift_en = 1'b1;
          if (bit_cnt_r == CNT_LAST) begin
            bit_cnt_s = {CNT_W{1'b0}};
            state_s   = STORE;
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
          end
        end else if (tx_finish) begin
          // Partial word is abandoned; the message is short.
          err_set_s = 1'b1;
          bit_cnt_s = {CNT_W{1'b0}};
          state_s   = DONE;
        end else begin
          state_s = RECV;
        end
      end
      STORE: begin
        store     = 1'b1;
        err_set_s = tx_valid;
        if (last_word) begin
          state_s = FULL;
        end else begin
          state_s = READY;
        end
      end
      FULL: begin
        err_set_s = tx_valid;
        if (tx_finish) begin
          state_s = DONE;
        end else begin
          state_s = FULL;
        end
      end
      DONE: begin
        err_set_s = tx_valid;
        state_s   = DONE;
      end
      default: begin
        state_s   = READY;
        bit_cnt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and status registers; status is decoded from the next state
  // so it tracks the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= READY;
      bit_cnt_r <= {CNT_W{1'b0}};
      rx_ready  <= 1'b1;
      rx_done   <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      rx_ready  <= (state_s == READY) || (state_s == RECV);
      rx_done   <= (state_s == DONE);
      rx_error  <= rx_error | err_set_s;
    end
  end

endmodule

// File: rtl/rx.sv
// Serial receiver top: shift register, message buffer, read port and status.
// Optional running XOR checksum of stored words when RX_CHECKSUM_EN is defined.
module rx
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  rx_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  shift_en_s;
  logic                  store_s;
  logic                  last_word_s;
  logic [DATA_WIDTH-1:0] shr_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [ADDR_WIDTH:0]   word_count_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  assign last_word_s = (wr_addr_r == {ADDR_WIDTH{1'b1}});

  rx_sm #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sm (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (bus.tx_valid),
    .tx_finish (bus.tx_finish),
    .last_word (last_word_s),
    .shift_en  (shift_en_s),
    .store     (store_s),
    .rx_ready  (bus.rx_ready),
    .rx_error  (bus.rx_error),
    .rx_done   (bus.rx_done)
  );

  // LSB-first deserialiser: each accepted bit enters at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shr_r <= {DATA_WIDTH{1'b0}};
    end else if (shift_en_s) begin
      shr_r <= {bus.tx_data, shr_r[DATA_WIDTH-1:1]};
    end else begin
      shr_r <= shr_r;
    end
  end

  // Buffer write; wr_addr wraps while word_count saturates at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_r    <= {ADDR_WIDTH{1'b0}};
      word_count_r <= {(ADDR_WIDTH + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (store_s) begin
      mem_r[wr_addr_r] <= shr_r;
      wr_addr_r        <= wr_addr_r + 1'b1;
      word_count_r     <= word_count_r + 1'b1;
    end else begin
      wr_addr_r    <= wr_addr_r;
      word_count_r <= word_count_r;
    end
  end

  // Registered read port; a same-cycle write is not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_data_r <= mem_r[bus.rd_addr];
    end
  end

  assign bus.rd_data    = rd_data_r;
  assign bus.word_count = word_count_r;

`ifdef RX_CHECKSUM_EN
  function automatic logic [DATA_WIDTH-1:0] csum_fold(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] word
  );
    return acc ^ word;
  endfunction

  logic [DATA_WIDTH-1:0] checksum_r;

  // Accumulate every word as it is committed to the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= {DATA_WIDTH{1'b0}};
    end else if (store_s) begin
      checksum_r <= csum_fold(checksum_r, shr_r);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign bus.rx_checksum = checksum_r;
`else
  assign bus.rx_checksum = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rx.sv
// Randomised bench for rx against a message-level reference model.
module tb_rx;
  import rx_pkg::*;

  localparam int DW    = DATA_WIDTH_DEF;
  localparam int AW    = ADDR_WIDTH_DEF;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Message-level model: what the buffer and status must hold.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_count;
  bit            m_err;
  bit            m_done;
  logic [DW-1:0] m_csum;

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_count = 0;
    m_err   = 1'b0;
    m_done  = 1'b0;
    m_csum  = '0;
  endfunction

  function automatic void m_word(input logic [DW-1:0] w);
    if (!m_done && m_count < DEPTH) begin
      m_mem[m_count] = w;
      m_count++;
      m_csum = m_csum ^ w;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  function automatic void m_finish();
    if (!m_done) begin
      if (m_count < DEPTH) m_err = 1'b1;
      m_done = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_finish = 1'b0;
    bus.tx_data   = 1'b0;
    bus.rd_addr   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  // Called on a negedge; returns on a negedge with tx_valid low.
  task automatic drive_word(input logic [DW-1:0] w, input int gap,
                            input int nbits, input bit wait_rdy);
    int guard;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0 && wait_rdy) begin
        guard = 0;
        while (bus.rx_ready !== 1'b1 && guard < 64) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 64) chk("ready_wait", 32'(bus.rx_ready), 32'd1);
      end
      bus.tx_valid = 1'b1;
      bus.tx_data  = w[i];
      @(negedge clk);
      bus.tx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_finish();
    @(negedge clk);
    bus.tx_finish = 1'b1;
    @(negedge clk);
    bus.tx_finish = 1'b0;
  endtask

  task automatic check_all(input string pfx);
    logic [31:0] exp_ready;
    repeat (2) @(negedge clk);
    exp_ready = (!m_done && m_count < DEPTH) ? 32'd1 : 32'd0;
    chk({pfx, "_count"}, 32'(bus.word_count), 32'(m_count));
    chk({pfx, "_done"},  32'(bus.rx_done),    32'(m_done));
    chk({pfx, "_error"}, 32'(bus.rx_error),   32'(m_err));
    chk({pfx, "_ready"}, 32'(bus.rx_ready),   exp_ready);
`ifdef RX_CHECKSUM_EN
    chk({pfx, "_csum"}, 32'(bus.rx_checksum), 32'(m_csum));
`else
    chk({pfx, "_csum"}, 32'(bus.rx_checksum), 32'd0);
`endif
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = AW'(a);
      @(negedge clk);
      chk($sformatf("%s_mem%0d", pfx, a), 32'(bus.rd_data), 32'(m_mem[a]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] dir_words [4];
    int            nw;
    dir_words[0] = 8'hA5; dir_words[1] = 8'h3C;
    dir_words[2] = 8'hFF; dir_words[3] = 8'h00;
    bus.tx_valid = 1'b0; bus.tx_finish = 1'b0;
    bus.tx_data  = 1'b0; bus.rd_addr   = '0;
    m_reset();

    do_reset();
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check_all("rst");

    // Full message back-to-back.
    for (int k = 0; k < 4; k++) begin
      drive_word(dir_words[k], 0, DW, 1'b1);
      m_word(dir_words[k]);
    end
    pulse_finish(); m_finish();
    check_all("full_msg");
`ifdef RX_CHECKSUM_EN
    chk("full_msg_csum_const", 32'(bus.rx_checksum), 32'h66);
`endif

    // Gapped bits.
    do_reset();
    drive_word(8'h81, 3, DW, 1'b1); m_word(8'h81);
    check_all("gapped");

    // Short message.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      w = DW'($urandom);
      drive_word(w, 0, DW, 1'b1); m_word(w);
    end
    pulse_finish(); m_finish();
    check_all("short");

    // Overrun burst into a full buffer.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w = DW'($urandom);
      drive_word(w, $urandom_range(0, 1), DW, 1'b1); m_word(w);
    end
    drive_word(DW'($urandom), 0, DW, 1'b0); m_word(8'h00);
    check_all("overrun");
    pulse_finish(); m_finish();
    check_all("overrun_fin");

    // Valid during the STORE cycle.
    do_reset();
    w = DW'($urandom);
    drive_word(w, 0, DW, 1'b1); m_word(w);
    bus.tx_valid = 1'b1; bus.tx_data = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0; m_err = 1'b1;
    w = DW'($urandom);
    drive_word(w, 0, DW, 1'b1); m_word(w);
    check_all("store_valid");

    // Reset in the middle of word 1.
    do_reset();
    w = DW'($urandom);
    drive_word(w, 0, DW, 1'b1);
    drive_word(DW'($urandom), 0, 5, 1'b1);
    do_reset();
    chk("midrst_rd_data", 32'(bus.rd_data), 32'd0);
    check_all("midrst");
    drive_word(8'h5A, 0, DW, 1'b1); m_word(8'h5A);
    check_all("after_rst");

    // Random messages with random pacing and optional finish.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      nw = $urandom_range(1, DEPTH);
      for (int k = 0; k < nw; k++) begin
        w = DW'($urandom);
        drive_word(w, $urandom_range(0, 2), DW, 1'b1); m_word(w);
      end
      if ($urandom_range(0, 3) != 0) begin
        pulse_finish(); m_finish();
      end
      check_all($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
